ble_crc_serializer: RTL and testbench

//  Upstream neighbour of the data whitener: pulls PDU bytes over a valid/ready handshake,

---
 rtl/ble_crc_serializer.sv | 164 ++++++++++++++++
 tb/tb_ble_crc_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ble_crc_serializer.sv
// BLE PDU serializer: pulls bytes over valid/ready, emits them LSB-first, then appends CRC-24.
// Optional CRC stage guarded by BLE_SER_CRC_EN; when undefined the frame ends after the PDU.
// Ports: pka_1or2m_gclk/r_tx_rst_n clock and async reset; fsm_ser_start samples pdu_len,
//  crc_init; byte_data/byte_valid/byte_ready byte handshake; bit_tick bit strobe;
//  r_data/vld_data_coded bit stream to whitener; ser_busy/ser_done/ser_underrun status;
//  crc_out live CRC register (0 without BLE_SER_CRC_EN).
module ble_crc_serializer #(
  parameter int          LEN_W    = 8,
  parameter logic [23:0] CRC_POLY = 24'h00065B
) (
  input  logic             pka_1or2m_gclk,
  input  logic             r_tx_rst_n,
  input  logic             fsm_ser_start,
  input  logic [LEN_W-1:0] pdu_len,
  input  logic [23:0]      crc_init,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             bit_tick,
  output logic             r_data,
  output logic             vld_data_coded,
  output logic             ser_busy,
  output logic             ser_done,
  output logic             ser_underrun,
  output logic [23:0]      crc_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PDU,
    S_CRC,
    S_DONE
  } state_t;

`ifdef BLE_SER_CRC_EN
  localparam state_t PDU_END = S_CRC;
`else
  localparam state_t PDU_END = S_DONE;
`endif

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_cnt;
  logic [LEN_W-1:0] emit_cnt;
  logic [7:0]       hold;
  logic             hold_full;
  logic [2:0]       bit_idx;
  logic             r_data_q;
  logic             vld_q;
  logic             underrun_q;

`ifdef BLE_SER_CRC_EN
  logic [23:0] crc;
  logic [4:0]  crc_cnt;

  function automatic logic [23:0] crc_step(
    input logic [23:0] c,
    input logic        b
  );
    crc_step = {c[22:0], 1'b0} ^ ((c[23] ^ b) ? CRC_POLY : 24'h0);
  endfunction

  assign crc_out = crc;
`else
  logic unused_crc_cfg;
  assign unused_crc_cfg = ^{crc_init, CRC_POLY};
  assign crc_out = 24'h0;
`endif

  // Ready only while a byte of this frame is still owed and the hold reg is free.
  assign byte_ready = (state == S_PDU) && !hold_full
                      && (acc_cnt != len_q);

  assign r_data         = r_data_q;
  assign vld_data_coded = vld_q;
  assign ser_busy       = (state != S_IDLE);
  assign ser_done       = (state == S_DONE);
  assign ser_underrun   = underrun_q;

  always_ff @(posedge pka_1or2m_gclk or negedge r_tx_rst_n) begin
    if (!r_tx_rst_n) begin
      state      <= S_IDLE;
      len_q      <= '0;
      acc_cnt    <= '0;
      emit_cnt   <= '0;
      hold       <= 8'h0;
      hold_full  <= 1'b0;
      bit_idx    <= 3'd0;
      r_data_q   <= 1'b0;
      vld_q      <= 1'b0;
      underrun_q <= 1'b0;
`ifdef BLE_SER_CRC_EN
      crc        <= 24'h0;
      crc_cnt    <= 5'd0;
`endif
    end else begin
      vld_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (fsm_ser_start) begin
            len_q      <= pdu_len;
            acc_cnt    <= '0;
            emit_cnt   <= '0;
            bit_idx    <= 3'd0;
            hold_full  <= 1'b0;
            underrun_q <= 1'b0;
`ifdef BLE_SER_CRC_EN
            crc        <= crc_init;
            crc_cnt    <= 5'd0;
`endif
            state <= (pdu_len != '0) ? S_PDU : PDU_END;
          end
        end
        S_PDU: begin
          // Fill and emit are exclusive: fill needs empty, emit needs full.
          if (byte_valid && byte_ready) begin
            hold      <= byte_data;
            hold_full <= 1'b1;
            acc_cnt   <= acc_cnt + LEN_W'(1);
          end
          if (bit_tick) begin
            if (hold_full) begin
              r_data_q <= hold[bit_idx];
              vld_q    <= 1'b1;
              bit_idx  <= bit_idx + 3'd1;
`ifdef BLE_SER_CRC_EN
              crc      <= crc_step(crc, hold[bit_idx]);
`endif
              if (bit_idx == 3'd7) begin
                hold_full <= 1'b0;
                emit_cnt  <= emit_cnt + LEN_W'(1);
                if (emit_cnt == len_q - LEN_W'(1)) begin
                  state <= PDU_END;
                end
              end
            end else begin
              underrun_q <= 1'b1;
            end
          end
        end
`ifdef BLE_SER_CRC_EN
        S_CRC: begin
          if (bit_tick) begin
            r_data_q <= crc[23];
            vld_q    <= 1'b1;
            crc      <= {crc[22:0], 1'b0};
            crc_cnt  <= crc_cnt + 5'd1;
            if (crc_cnt == 5'd23) begin
              state <= S_DONE;
            end
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ble_crc_serializer.sv
// Testbench for ble_crc_serializer: table of frames plus underrun/reset sequence.
// Expected bit stream is built by a reference model and checked from a queue.
module tb_ble_crc_serializer;

`ifdef BLE_SER_CRC_EN
  localparam int CRCB = 24;
`else
  localparam int CRCB = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  len = 8'h0;
  logic [23:0] cinit = 24'h0;
  logic [7:0]  bdata = 8'h0;
  logic        bvalid = 1'b0;
  logic        tick = 1'b0;
  logic        ready;
  logic        r_data;
  logic        vld;
  logic        busy;
  logic        done;
  logic        urun;
  logic [23:0] crc_out;

  ble_crc_serializer #(.LEN_W(8), .CRC_POLY(24'h00065B)) dut (
    .pka_1or2m_gclk (clk),
    .r_tx_rst_n     (rst_n),
    .fsm_ser_start  (start),
    .pdu_len        (len),
    .crc_init       (cinit),
    .byte_data      (bdata),
    .byte_valid     (bvalid),
    .byte_ready     (ready),
    .bit_tick       (tick),
    .r_data         (r_data),
    .vld_data_coded (vld),
    .ser_busy       (busy),
    .ser_done       (done),
    .ser_underrun   (urun),
    .crc_out        (crc_out)
  );

  always #5 clk = ~clk;

  int   npass = 0;
  int   ntot  = 0;
  int   nvld  = 0;
  logic exp_q[$];

  typedef struct {
    logic [7:0]  len;
    logic [31:0] bytes;
    logic [23:0] ci;
    int          div;
    int          nbits;
    logic        urun;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && vld) begin
      nvld++;
      if (exp_q.size() == 0) chk("extra_bit", 32'd1, 32'd0);
      else chk("bit", {31'd0, r_data}, {31'd0, exp_q.pop_front()});
    end
  end

  task automatic push_frame(input vec_t v);
    logic [23:0] c;
    logic        b;
    c = v.ci;
    for (int i = 0; i < int'(v.len); i++) begin
      for (int k = 0; k < 8; k++) begin
        b = v.bytes[8*i+k];
        exp_q.push_back(b);
        c = {c[22:0], 1'b0} ^ ((c[23] ^ b) ? 24'h00065B : 24'h0);
      end
    end
    for (int k = 0; k < CRCB; k++) begin
      exp_q.push_back(c[23]);
      c = {c[22:0], 1'b0};
    end
  endtask

  task automatic check_reset(input string nm);
    chk({nm, "_rdata"}, {31'd0, r_data}, 32'd0);
    chk({nm, "_vld"},   {31'd0, vld},    32'd0);
    chk({nm, "_busy"},  {31'd0, busy},   32'd0);
    chk({nm, "_done"},  {31'd0, done},   32'd0);
    chk({nm, "_urun"},  {31'd0, urun},   32'd0);
    chk({nm, "_ready"}, {31'd0, ready},  32'd0);
    chk({nm, "_crc"},   {8'd0, crc_out}, 32'd0);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int   bi;
    int   dv;
    int   cyc;
    logic fire;
    string t;
    bi = 0; dv = 0; cyc = 0;
    t = $sformatf("v%0d", idx);
    nvld = 0;
    push_frame(v);
    @(negedge clk);
    start = 1'b1; len = v.len; cinit = v.ci;
    @(negedge clk);
    start = 1'b0;
    chk({t, "_crc_load"}, {8'd0, crc_out},
        (CRCB != 0) ? {8'd0, v.ci} : 32'd0);
    while (!done && cyc < 2000) begin
      bvalid = (bi < int'(v.len));
      bdata  = (bi < 4) ? v.bytes[8*bi +: 8] : 8'h0;
      tick   = (dv == v.div - 1);
      dv     = (dv + 1) % v.div;
      fire   = bvalid && ready;
      @(negedge clk);
      cyc++;
      if (fire) bi++;
    end
    bvalid = 1'b0;
    tick   = 1'b0;
    chk({t, "_done"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({t, "_nvld"}, nvld, v.nbits);
    chk({t, "_qempty"}, exp_q.size(), 32'd0);
    chk({t, "_urun"}, {31'd0, urun}, {31'd0, v.urun});
    chk({t, "_idle"}, {31'd0, busy}, 32'd0);
    chk({t, "_crc_end"}, {8'd0, crc_out}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] a5;
    logic       fire;
    vecs[0] = '{8'd0, 32'h0,        24'h555555, 1, CRCB,      1'b0};
    vecs[1] = '{8'd1, 32'h0,        24'h000000, 1, 8 + CRCB,  1'b1};
    vecs[2] = '{8'd2, 32'h00003CA5, 24'h000000, 3, 16 + CRCB, 1'b0};
    vecs[3] = '{8'd3, 32'h00563412, 24'h123456, 2, 24 + CRCB, 1'b0};
    vecs[4] = '{8'd2, 32'h000081FF, 24'hABCDEF, 1, 16 + CRCB, 1'b1};

    #2;
    check_reset("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Second byte withheld: ticks keep coming with nothing held.
    a5 = 8'hA5;
    nvld = 0;
    for (int k = 0; k < 8; k++) exp_q.push_back(a5[k]);
    @(negedge clk);
    start = 1'b1; len = 8'd2; cinit = 24'h0;
    @(negedge clk);
    start = 1'b0;
    bvalid = 1'b1;
    bdata  = 8'hA5;
    for (int c = 0; c < 30; c++) begin
      tick = c[0];
      fire = bvalid && ready;
      @(negedge clk);
      if (fire) bvalid = 1'b0;
    end
    tick = 1'b0;
    chk("ur_nvld",  nvld, 32'd8);
    chk("ur_urun",  {31'd0, urun},  32'd1);
    chk("ur_busy",  {31'd0, busy},  32'd1);
    chk("ur_ready", {31'd0, ready}, 32'd1);
    chk("ur_rdata", {31'd0, r_data}, 32'd1);

    // Start while busy must not restart the frame.
    start = 1'b1; len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_urun", {31'd0, urun}, 32'd1);
    chk("busy_start_done", {31'd0, done}, 32'd0);

    // Asynchronous reset away from any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("mid");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_busy",  {31'd0, busy},  32'd0);
    chk("post_ready", {31'd0, ready}, 32'd0);

    // Frame after reset still works.
    run_frame(vecs[2], 5);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
